// File: rtl/alu_pkg.sv
// Shared ALU definitions for the execute stage.
// Holds the 4-bit ALU_Control operation codes produced by the ALU control
// decoder, the state encoding of the multi-cycle multiply/divide unit, and
// a helper that recognises the codes handled by that unit.
package alu_pkg;

   // ALU_Control operation codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_NOR = 4'b0100;
   localparam logic [3:0] ALU_MUL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_DIV = 4'b1011;

   // Multiply/divide unit states
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ITER = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   // True for the operations that the multi-cycle unit executes
   function automatic logic is_mul_div(input logic [3:0] code);
      return (code == ALU_MUL) || (code == ALU_DIV);
   endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the unsigned shift-add multiplier / restoring divider.
// Purely combinational; the caller registers acc_next each cycle.
// Ports:
//   is_div   - 1 selects a divide step, 0 a multiply step
//   acc      - 2*WIDTH accumulator {high half, low half}
//              multiply: {partial product, remaining multiplier bits}
//              divide:   {partial remainder, dividend/quotient bits}
//   operand  - multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_next - accumulator after this step (bit 0 left clear on divide)
//   q_bit    - quotient bit produced by a divide step, 0 on multiply
module mul_div_step #(
   parameter int WIDTH = 32
) (
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   acc_next,
   output logic                 q_bit
);

   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] shifted;
   logic [WIDTH:0]     trial;

   // Multiply: add the multiplicand into the high half when the current
   // multiplier bit (acc[0]) is set, keeping the carry so the right shift
   // brings it back into the top bit of the accumulator.
   // Divide: shift left, try subtracting the divisor from the high half;
   // a borrow in the extra top bit means restore (keep the shifted value).
   // The partial remainder stays below the divisor (at most 2^(WIDTH-1)),
   // so the shifted high half never overflows WIDTH bits.
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      shifted  = {acc[2*WIDTH-2:0], 1'b0};
      trial    = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, operand};
      acc_next = '0;
      q_bit    = 1'b0;
      if (is_div) begin
         if (!trial[WIDTH]) begin
            acc_next = {trial[WIDTH-1:0], shifted[WIDTH-1:0]};
            q_bit    = 1'b1;
         end else begin
            acc_next = shifted;
         end
      end else begin
         acc_next = {sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply/divide unit for the execute stage.
// Works on operand magnitudes one bit per cycle and applies the signs at
// the end; stalls the pipeline while an operation is in flight.
// Ports:
//   Clk, Reset_n      - clock, asynchronous active-low reset
//   Start             - EX instruction valid (only looked at in IDLE)
//   ALU_Control       - operation code; MUL and DIV are accepted
//   A, B              - signed operands (multiplicand/dividend, multiplier/divisor)
//   Flush             - synchronous abort from a branch/jump flush
//   Busy              - operation in progress (registered)
//   Stall             - hold IF/ID/EX (combinational)
//   Done              - one-cycle completion pulse
//   Result, Hi        - low product/quotient and high product/remainder
//   DivByZero         - divide by zero flag, valid with Done
module mul_div_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [3:0]       ALU_Control,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Flush,
   output logic             Busy,
   output logic             Stall,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] Hi,
   output logic             DivByZero
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [1:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opb;
   logic               sa;
   logic               sb;
   logic               op_div;
   logic               dbz;

   logic               valid_code;
   logic               accept;
   logic               new_div;
   logic               b_zero;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] step_acc;
   logic               step_q;
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   fix_res;
   logic [WIDTH-1:0]   fix_hi;

   mul_div_step #(.WIDTH(WIDTH)) u_step (
      .is_div   (op_div),
      .acc      (acc),
      .operand  (opb),
      .acc_next (step_acc),
      .q_bit    (step_q)
   );

   // Accept decode and operand magnitudes. A flush in the accept cycle
   // kills the instruction, but the stall request still follows Start so
   // the hazard logic sees a consistent hold until the flush lands.
   always_comb begin
      valid_code = is_mul_div(ALU_Control);
      accept     = (state == IDLE) && Start && valid_code && !Flush;
      new_div    = (ALU_Control == ALU_DIV);
      b_zero     = (B == '0);
      mag_a      = A[WIDTH-1] ? -A : A;
      mag_b      = B[WIDTH-1] ? -B : B;
      Stall      = ((state == IDLE) && Start && valid_code) | Busy;
   end

   // Final sign correction. On a divide by zero the dividend magnitude is
   // still sitting untouched in the low half, so re-applying its sign
   // recovers the original A for Hi.
   always_comb begin
      prod_signed = (sa ^ sb) ? -acc : acc;
      fix_res     = '0;
      fix_hi      = '0;
      if (!op_div) begin
         fix_res = prod_signed[WIDTH-1:0];
         fix_hi  = prod_signed[2*WIDTH-1:WIDTH];
      end else if (dbz) begin
         fix_res = '1;
         fix_hi  = sa ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end else begin
         fix_res = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         fix_hi  = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
   end

   // Control FSM and datapath registers. Multiply keeps the multiplier in
   // the low half of the accumulator and the multiplicand in opb; divide
   // keeps the dividend in the low half and the divisor in opb. A divide
   // by zero skips the iterations and goes straight to FIX. Flush wins
   // over completion, and Result/Hi only change on a real completion.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         opb       <= '0;
         sa        <= 1'b0;
         sb        <= 1'b0;
         op_div    <= 1'b0;
         dbz       <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Result    <= '0;
         Hi        <= '0;
         DivByZero <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  sa        <= A[WIDTH-1];
                  sb        <= B[WIDTH-1];
                  op_div    <= new_div;
                  dbz       <= new_div && b_zero;
                  acc       <= {{WIDTH{1'b0}}, (new_div ? mag_a : mag_b)};
                  opb       <= new_div ? mag_b : mag_a;
                  cnt       <= CNT_W'(WIDTH - 1);
                  Busy      <= 1'b1;
                  DivByZero <= 1'b0;
                  state     <= (new_div && b_zero) ? FIX : ITER;
               end
            end
            ITER: begin
               if (Flush) begin
                  Busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  acc <= {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
                  cnt <= cnt - 1'b1;
                  if (cnt == '0) begin
                     state <= FIX;
                  end
               end
            end
            FIX: begin
               Busy  <= 1'b0;
               state <= IDLE;
               if (!Flush) begin
                  Result    <= fix_res;
                  Hi        <= fix_hi;
                  DivByZero <= dbz;
                  Done      <= 1'b1;
               end
            end
            default: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH = 32).
// Table of signed MUL/DIV vectors with hand-derived results, a few random
// vectors checked against a behavioural model, and hand-written sequences
// for ignored codes, Start while busy, Flush and asynchronous reset.
// Expected results go into a scoreboard queue when an operation is issued
// and are popped when Done appears.
module tb_mul_div_unit;
   import alu_pkg::*;

   localparam int W = 32;

   logic          Clk = 1'b0;
   logic          Reset_n;
   logic          Start;
   logic [3:0]    ALU_Control;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          Flush;
   logic          Busy;
   logic          Stall;
   logic          Done;
   logic [W-1:0]  Result;
   logic [W-1:0]  Hi;
   logic          DivByZero;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         dbz;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         dbz;
   } exp_t;

   vec_t          vecs[12];
   exp_t          sbq[$];
   int            total = 0;
   int            bad = 0;
   logic [W-1:0]  lastRes = '0;
   logic [W-1:0]  lastHi = '0;

   mul_div_unit #(.WIDTH(W)) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .Start       (Start),
      .ALU_Control (ALU_Control),
      .A           (A),
      .B           (B),
      .Flush       (Flush),
      .Busy        (Busy),
      .Stall       (Stall),
      .Done        (Done),
      .Result      (Result),
      .Hi          (Hi),
      .DivByZero   (DivByZero)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Independent reference: native signed arithmetic, with the two
   // cases the hardware defines specially handled first.
   task automatic modelOp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic [W-1:0] hi, output logic dbz);
      longint p;
      int     sa;
      int     sb;
      sa  = $signed(a);
      sb  = $signed(b);
      dbz = 1'b0;
      if (op == ALU_MUL) begin
         p   = longint'(sa) * longint'(sb);
         res = p[31:0];
         hi  = p[63:32];
      end else if (b == '0) begin
         res = '1;
         hi  = a;
         dbz = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         res = 32'h8000_0000;
         hi  = '0;
      end else begin
         res = sa / sb;
         hi  = sa % sb;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic [W-1:0] hi, input logic dbz);
      exp_t e;
      Start       = 1'b1;
      ALU_Control = op;
      A           = a;
      B           = b;
      e.res       = res;
      e.hi        = hi;
      e.dbz       = dbz;
      sbq.push_back(e);
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      if (sbq.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL %s_unexpected_done: got Done=1 want no Done", tag);
      end else begin
         e = sbq.pop_front();
         checkVal({tag, "_result"}, 64'(Result), 64'(e.res));
         checkVal({tag, "_hi"}, 64'(Hi), 64'(e.hi));
         checkVal({tag, "_dbz"}, 64'(DivByZero), 64'(e.dbz));
         lastRes = e.res;
         lastHi  = e.hi;
      end
   endtask

   // Issue one operation at the next edge N and follow it to Done.
   // intrudeAt > 0 raises Start with a MUL so that edge N+intrudeAt sees it.
   task automatic runOp(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res, input logic [W-1:0] hi, input logic dbz,
                        input int expLat, input int intrudeAt);
      int cyc;
      bit seen;
      @(negedge Clk);
      applyStimulus(op, a, b, res, hi, dbz);
      #1;
      checkVal({tag, "_stall_accept"}, 64'(Stall), 64'd1);
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      checkVal({tag, "_busy"}, 64'(Busy), 64'd1);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 80) begin
         if (intrudeAt > 0 && cyc == intrudeAt - 1) begin
            Start       = 1'b1;
            ALU_Control = ALU_MUL;
            A           = 32'd3;
            B           = 32'd3;
         end else if (intrudeAt > 0 && cyc == intrudeAt) begin
            Start = 1'b0;
         end
         @(posedge Clk);
         cyc++;
         @(negedge Clk);
         if (Done) seen = 1'b1;
      end
      Start = 1'b0;
      if (!seen) begin
         total++;
         bad++;
         $display("[TB] FAIL %s_timeout: got no Done want Done", tag);
         if (sbq.size() > 0) void'(sbq.pop_front());
      end else begin
         checkVal({tag, "_latency"}, 64'(cyc), 64'(expLat));
         checkOutput(tag);
         checkVal({tag, "_busy_done"}, 64'(Busy), 64'd0);
         checkVal({tag, "_stall_done"}, 64'(Stall), 64'd0);
         @(posedge Clk);
         @(negedge Clk);
         checkVal({tag, "_done_pulse"}, 64'(Done), 64'd0);
      end
   endtask

   initial begin
      int           doneCnt;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] mres;
      logic [W-1:0] mhi;
      logic         mdbz;
      logic [3:0]   rop;

      vecs[0]  = '{ALU_MUL, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0};
      vecs[1]  = '{ALU_MUL, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 1'b0};
      vecs[2]  = '{ALU_MUL, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0};
      vecs[3]  = '{ALU_DIV, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
      vecs[4]  = '{ALU_DIV, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
      vecs[5]  = '{ALU_DIV, 32'd5,          32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1};
      vecs[6]  = '{ALU_MUL, 32'd3,          32'd4,         32'd12,        32'd0,         1'b0};
      vecs[7]  = '{ALU_DIV, 32'd100,        32'd7,         32'd14,        32'd2,         1'b0};
      vecs[8]  = '{ALU_DIV, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0};
      vecs[9]  = '{ALU_MUL, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
      vecs[10] = '{ALU_DIV, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0};
      vecs[11] = '{ALU_DIV, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1};

      Reset_n     = 1'b0;
      Start       = 1'b0;
      ALU_Control = ALU_AND;
      A           = '0;
      B           = '0;
      Flush       = 1'b0;
      #12;
      checkVal("reset_busy", 64'(Busy), 64'd0);
      checkVal("reset_done", 64'(Done), 64'd0);
      checkVal("reset_stall", 64'(Stall), 64'd0);
      checkVal("reset_result", 64'(Result), 64'd0);
      checkVal("reset_hi", 64'(Hi), 64'd0);
      checkVal("reset_dbz", 64'(DivByZero), 64'd0);
      @(negedge Clk);
      Reset_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].res, vecs[i].hi, vecs[i].dbz, vecs[i].dbz ? 1 : W + 1, 0);
      end

      for (int i = 0; i < 6; i++) begin
         rop = (i % 2 == 0) ? ALU_MUL : ALU_DIV;
         ra  = $urandom;
         rb  = (i == 5) ? 32'd0 : $urandom_range(1, 50000) * ((i % 3 == 0) ? 1 : -1);
         modelOp(rop, ra, rb, mres, mhi, mdbz);
         runOp($sformatf("rnd%0d", i), rop, ra, rb, mres, mhi, mdbz, mdbz ? 1 : W + 1, 0);
      end

      // Non MUL/DIV code is ignored entirely
      @(negedge Clk);
      Start       = 1'b1;
      ALU_Control = ALU_ADD;
      A           = 32'd1;
      B           = 32'd2;
      #1;
      checkVal("add_stall", 64'(Stall), 64'd0);
      doneCnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (Busy || Done) doneCnt++;
      end
      Start = 1'b0;
      checkVal("add_ignored", 64'(doneCnt), 64'd0);

      // Start with MUL at edge N+5 of a DIV must not disturb it
      runOp("intrude", ALU_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, W + 1, 5);

      // Flush in IDLE suppresses the accept
      @(negedge Clk);
      Start       = 1'b1;
      ALU_Control = ALU_MUL;
      A           = 32'd9;
      B           = 32'd9;
      Flush       = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      Flush = 1'b0;
      checkVal("flush_idle_busy", 64'(Busy), 64'd0);

      // Flush at edge N+10 of a MUL: no Done, outputs held
      Start = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start   = 1'b0;
      doneCnt = 0;
      for (int c = 0; c < 10; c++) begin
         if (c == 9) Flush = 1'b1;
         @(posedge Clk);
         @(negedge Clk);
         if (Done) doneCnt++;
      end
      Flush = 1'b0;
      checkVal("flush_busy", 64'(Busy), 64'd0);
      for (int c = 0; c < 40; c++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (Done) doneCnt++;
      end
      checkVal("flush_no_done", 64'(doneCnt), 64'd0);
      checkVal("flush_result_held", 64'(Result), 64'(lastRes));
      checkVal("flush_hi_held", 64'(Hi), 64'(lastHi));

      // Asynchronous reset in the middle of a MUL
      Start       = 1'b1;
      ALU_Control = ALU_MUL;
      A           = 32'd9;
      B           = 32'd9;
      @(posedge Clk);
      @(negedge Clk);
      Start   = 1'b0;
      doneCnt = 0;
      for (int c = 0; c < 19; c++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (Done) doneCnt++;
      end
      #2;
      Reset_n = 1'b0;
      #1;
      checkVal("arst_busy", 64'(Busy), 64'd0);
      checkVal("arst_stall", 64'(Stall), 64'd0);
      checkVal("arst_result", 64'(Result), 64'd0);
      checkVal("arst_hi", 64'(Hi), 64'd0);
      checkVal("arst_dbz", 64'(DivByZero), 64'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (Done) doneCnt++;
      end
      checkVal("arst_no_done", 64'(doneCnt), 64'd0);
      lastRes = '0;
      lastHi  = '0;
      runOp("after_reset", ALU_MUL, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0, W + 1, 0);

      checkVal("scoreboard_empty", 64'(sbq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
